// File: rtl/countdown_sched_if.sv
// Control and status bundle for the countdown sequencer. The master side drives
// configuration and run control; the slave side returns ticks and countdown status.
interface countdown_sched_if #(
  parameter int CNT_W = 8
);
  logic [31:0]      cfg_div;
  logic             cfg_load;
  logic [CNT_W-1:0] load_val;
  logic             start;
  logic             pause;
  logic             clear;
  logic             tick_out;
  logic             half_out;
  logic [CNT_W-1:0] remaining;
  logic             done;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output cfg_div, cfg_load, load_val, start, pause, clear,
    input  tick_out, half_out, remaining, done, busy, state
  );

  modport slave (
    input  cfg_div, cfg_load, load_val, start, pause, clear,
    output tick_out, half_out, remaining, done, busy, state
  );
endinterface

// File: rtl/countdown_sched.sv
// Run/pause/clear-controlled prescaler with a countdown sequencer. tick_out is a
// one-cycle clock enable per prescaler wrap; done pulses when the count expires.
module countdown_sched #(
  parameter logic [31:0] DEFAULT_DIV = 32'd50_000_000,
  parameter int          CNT_W       = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  countdown_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  state_t           st_q,    st_nxt;
  logic [31:0]      pcnt_q,  pcnt_nxt;
  logic [31:0]      div_q,   div_nxt;   // period of the current run
  logic [31:0]      cfg_q,   cfg_nxt;   // period for the next start
  logic [CNT_W-1:0] rem_q,   rem_nxt;
  logic             tick_q,  tick_nxt;
  logic             half_q,  half_nxt;
  logic             done_q,  done_nxt;
  logic             busy_q,  busy_nxt;

  logic             idle_like;
  logic             wrap;

  assign idle_like = (st_q == IDLE) || (st_q == EXPIRED);
  assign wrap      = (pcnt_q == div_q - 32'd1);

  // NOTE: every variable gets a default before any branch, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    st_nxt   = st_q;
    pcnt_nxt = pcnt_q;
    div_nxt  = div_q;
    cfg_nxt  = cfg_q;
    rem_nxt  = rem_q;
    tick_nxt = 1'b0;
    done_nxt = 1'b0;

    // A period loaded alongside start only takes effect on the following start.
    if (idle_like && bus.cfg_load) begin
      cfg_nxt = (bus.cfg_div < 32'd2) ? 32'd2 : bus.cfg_div;
    end

    if (bus.clear) begin
      st_nxt   = IDLE;
      pcnt_nxt = '0;
      rem_nxt  = '0;
    end else begin
      case (st_q)
        IDLE, EXPIRED: begin
          if (bus.start) begin
            div_nxt  = cfg_q;
            pcnt_nxt = '0;
            rem_nxt  = bus.load_val;
            if (bus.load_val != '0) begin
              st_nxt = RUN;
            end else begin
              st_nxt   = EXPIRED;
              done_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (wrap) begin
            pcnt_nxt = '0;
            tick_nxt = 1'b1;
            if (rem_q != '0) rem_nxt = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              st_nxt   = EXPIRED;
              done_nxt = 1'b1;
            end
          end else begin
            pcnt_nxt = pcnt_q + 32'd1;
          end
          // Expiry on the same wrap outranks the pause request.
          if (bus.pause && st_nxt == RUN) st_nxt = PAUSE;
        end
        PAUSE: begin
          if (bus.start) st_nxt = RUN;
        end
        default: st_nxt = IDLE;
      endcase
    end

    busy_nxt = (st_nxt == RUN) || (st_nxt == PAUSE);
    half_nxt = (st_nxt == RUN) && (pcnt_nxt < (div_nxt >> 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      pcnt_q <= '0;
      div_q  <= DEFAULT_DIV;
      cfg_q  <= DEFAULT_DIV;
      rem_q  <= '0;
      tick_q <= 1'b0;
      half_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      pcnt_q <= pcnt_nxt;
      div_q  <= div_nxt;
      cfg_q  <= cfg_nxt;
      rem_q  <= rem_nxt;
      tick_q <= tick_nxt;
      half_q <= half_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.state     = st_q;
  assign bus.tick_out  = tick_q;
  assign bus.half_out  = half_q;
  assign bus.remaining = rem_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_countdown_sched.sv
// Bench for countdown_sched: an elapsed-cycle model checked every cycle, plus
// directed scenarios with hand-computed tick timing and countdown values.
module tb_countdown_sched;

  localparam int          CNT_W = 8;
  localparam logic [31:0] DEF   = 32'd10;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic clkin = 1'b0;
  logic rst_n;

  countdown_sched_if #(.CNT_W(CNT_W)) intf ();

  countdown_sched #(.DEFAULT_DIV(DEF), .CNT_W(CNT_W)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (intf)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a run is described by its start value, its period and the number of
  // RUN cycles counted so far; ticks and remaining follow by division.
  int          m_state;
  int unsigned m_n, m_elapsed, m_p, m_pend;
  bit          m_tick, m_done;

  task automatic model_reset();
    m_state = S_IDLE; m_n = 0; m_elapsed = 0; m_p = DEF; m_pend = DEF;
    m_tick = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit          idle_like;
    int unsigned old_pend;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tick    = 0;
    m_done    = 0;
    idle_like = (m_state == S_IDLE) || (m_state == S_EXP);
    old_pend  = m_pend;
    if (intf.clear) begin
      m_state = S_IDLE; m_n = 0; m_elapsed = 0;
    end else if (idle_like && intf.start) begin
      m_p = old_pend; m_n = intf.load_val; m_elapsed = 0;
      if (intf.load_val == 0) begin m_state = S_EXP; m_done = 1; end
      else m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      m_elapsed++;
      if (m_elapsed % m_p == 0) begin
        m_tick = 1;
        if (m_elapsed / m_p >= m_n) begin m_state = S_EXP; m_done = 1; end
      end
      if (intf.pause && m_state == S_RUN) m_state = S_PAUSE;
    end else if (m_state == S_PAUSE && intf.start) begin
      m_state = S_RUN;
    end
    if (idle_like && intf.cfg_load) m_pend = (intf.cfg_div < 2) ? 2 : intf.cfg_div;
  endtask

  // Per-cycle comparison, 1 time unit after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clkin);
      #1;
      model_step();
      if (chk_en) begin
        check("cyc_state", intf.state, m_state);
        check("cyc_remaining", intf.remaining,
              (m_state == S_IDLE) ? 0 : m_n - m_elapsed / m_p);
        check("cyc_tick", intf.tick_out, m_tick);
        check("cyc_done", intf.done, m_done);
        check("cyc_busy", intf.busy, (m_state == S_RUN) || (m_state == S_PAUSE));
        check("cyc_half", intf.half_out,
              (m_state == S_RUN) && ((m_elapsed % m_p) < (m_p / 2)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic do_start(input logic [CNT_W-1:0] v);
    intf.load_val = v; intf.start = 1'b1;
    adv(1);
    intf.start = 1'b0;
  endtask

  task automatic do_cfg(input logic [31:0] d);
    intf.cfg_div = d; intf.cfg_load = 1'b1;
    adv(1);
    intf.cfg_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    intf.cfg_div = '0; intf.cfg_load = 1'b0; intf.load_val = '0;
    intf.start = 1'b0; intf.pause = 1'b0; intf.clear = 1'b0;
    adv(3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset and idle
    adv(10);
    check("idle_state", intf.state, 0);
    check("idle_remaining", intf.remaining, 0);
    check("idle_tick", intf.tick_out, 0);
    check("idle_done", intf.done, 0);
    check("idle_busy", intf.busy, 0);

    // Period 4, count 3: ticks 4, 8, 12 cycles after RUN entry
    do_cfg(32'd4);
    do_start(8'd3);
    check("run_entry_state", intf.state, 1);
    check("run_entry_remaining", intf.remaining, 3);
    check("run_entry_half", intf.half_out, 1);
    adv(3);
    check("tick1_early", intf.tick_out, 0);
    adv(1);
    check("tick1", intf.tick_out, 1);
    check("tick1_remaining", intf.remaining, 2);
    adv(4);
    check("tick2", intf.tick_out, 1);
    check("tick2_remaining", intf.remaining, 1);
    adv(4);
    check("tick3", intf.tick_out, 1);
    check("tick3_remaining", intf.remaining, 0);
    check("tick3_done", intf.done, 1);
    check("tick3_state", intf.state, 3);
    check("tick3_busy", intf.busy, 0);
    adv(1);
    check("done_single_cycle", intf.done, 0);

    // Pause two cycles into the run, hold, resume without phase loss
    do_start(8'd5);
    adv(1);
    intf.pause = 1'b1;
    adv(1);
    intf.pause = 1'b0;
    check("pause_state", intf.state, 2);
    adv(20);
    check("pause_hold_remaining", intf.remaining, 5);
    check("pause_hold_half", intf.half_out, 0);
    do_start(8'd0);
    check("resume_state", intf.state, 1);
    adv(1);
    check("resume_tick_early", intf.tick_out, 0);
    adv(1);
    check("resume_tick", intf.tick_out, 1);
    check("resume_remaining", intf.remaining, 4);
    intf.clear = 1'b1;
    adv(1);
    intf.clear = 1'b0;

    // cfg_div=1 clamps to period 2; zero start value expires at once
    do_cfg(32'd1);
    do_start(8'd0);
    check("zero_state", intf.state, 3);
    check("zero_done", intf.done, 1);
    check("zero_tick", intf.tick_out, 0);
    adv(1);
    check("zero_done_clear", intf.done, 0);
    do_start(8'd1);
    adv(1);
    check("p2_tick_early", intf.tick_out, 0);
    adv(1);
    check("p2_tick", intf.tick_out, 1);
    check("p2_done", intf.done, 1);

    // clear beats start and pause on a wrap cycle
    do_cfg(32'd4);
    do_start(8'd3);
    adv(3);
    intf.clear = 1'b1; intf.start = 1'b1; intf.pause = 1'b1;
    adv(1);
    intf.clear = 1'b0; intf.start = 1'b0; intf.pause = 1'b0;
    check("clear_state", intf.state, 0);
    check("clear_remaining", intf.remaining, 0);
    check("clear_tick", intf.tick_out, 0);
    check("clear_done", intf.done, 0);

    // cfg_load during RUN is ignored; pause on a wrap; expiry beats pause
    do_start(8'd3);
    do_cfg(32'd8);
    adv(2);
    check("runcfg_tick_early", intf.tick_out, 0);
    adv(1);
    check("runcfg_tick", intf.tick_out, 1);
    check("runcfg_remaining", intf.remaining, 2);
    adv(3);
    intf.pause = 1'b1;
    adv(1);
    intf.pause = 1'b0;
    check("wrap_pause_state", intf.state, 2);
    check("wrap_pause_tick", intf.tick_out, 1);
    check("wrap_pause_remaining", intf.remaining, 1);
    do_start(8'd0);
    adv(3);
    intf.pause = 1'b1;
    adv(1);
    intf.pause = 1'b0;
    check("expire_pause_state", intf.state, 3);
    check("expire_pause_done", intf.done, 1);

    // cfg_load with start: this run keeps period 4, the next uses 6
    intf.cfg_div = 32'd6; intf.cfg_load = 1'b1;
    do_start(8'd1);
    intf.cfg_load = 1'b0;
    adv(4);
    check("same_cycle_old_period", intf.tick_out, 1);
    do_start(8'd1);
    adv(5);
    check("new_period_early", intf.tick_out, 0);
    adv(1);
    check("new_period_tick", intf.tick_out, 1);

    // Asynchronous reset mid-run, then default period
    do_start(8'd2);
    adv(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", intf.state, 0);
    check("async_remaining", intf.remaining, 0);
    check("async_busy", intf.busy, 0);
    check("async_half", intf.half_out, 0);
    adv(1);
    rst_n = 1'b1;
    do_start(8'd1);
    adv(9);
    check("default_tick_early", intf.tick_out, 0);
    adv(1);
    check("default_tick", intf.tick_out, 1);
    check("default_done", intf.done, 1);

    adv(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
